// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a sync_fifo and its user.
// The user side is master and the FIFO side is slave.
interface sync_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             push;
  logic [WIDTH-1:0] din;
  logic             pop;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             push_err;
  logic             pop_err;

  modport master (
    output flush, push, din, pop,
    input  dout, empty, full, almost_full, count, push_err, pop_err
  );

  modport slave (
    input  flush, push, din, pop,
    output dout, empty, full, almost_full, count, push_err, pop_err
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush,
// combinational status flags and one-cycle rejected-request error pulses.
module sync_fifo #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = 6
) (
  input  logic       clk,
  input  logic       rst,
  sync_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push_err_q;
  logic             pop_err_q;

  logic is_empty;
  logic is_full;
  logic push_ok;
  logic pop_ok;
  logic push_rej;
  logic pop_rej;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // A push into a full FIFO is accepted only when a pop frees a slot in the
  // same cycle; flush suppresses both requests and their error pulses.
  assign pop_ok   = bus.pop  && !bus.flush && !is_empty;
  assign push_ok  = bus.push && !bus.flush && (!is_full || bus.pop);
  assign pop_rej  = bus.pop  && !bus.flush && is_empty;
  assign push_rej = bus.push && !bus.flush && is_full && !bus.pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      push_err_q <= 1'b0;
      pop_err_q  <= 1'b0;
    end else begin
      push_err_q <= push_rej;
      pop_err_q  <= pop_rej;
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
        case ({push_ok, pop_ok})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_comb begin
    bus.dout = '0;
    if (!is_empty) bus.dout = mem[rd_ptr];
  end

  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
  assign bus.almost_full = (count_q >= CW'(AFULL_LEVEL));
  assign bus.count       = count_q;
  assign bus.push_err    = push_err_q;
  assign bus.pop_err     = pop_err_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed vector bench for sync_fifo at WIDTH=8, DEPTH=4, AFULL_LEVEL=3.
module tb_sync_fifo;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sync_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

  sync_fifo #(.WIDTH(8), .DEPTH(4), .AFULL_LEVEL(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [2:0] cnt;
    logic       emp;
    logic       ful;
    logic       af;
    logic [7:0] dout;
    logic       pe;
    logic       poe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic fl, logic pu, logic po, logic [7:0] di,
                              logic [2:0] c, logic e, logic f, logic a,
                              logic [7:0] d, logic pe, logic poe);
    vec_t v;
    v.flush = fl; v.push = pu; v.pop = po; v.din = di;
    v.cnt = c; v.emp = e; v.ful = f; v.af = a; v.dout = d; v.pe = pe; v.poe = poe;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic [2:0] c, input logic e,
                              input logic f, input logic a, input logic [7:0] d,
                              input logic pe, input logic poe);
    check({tag, " count"},       32'(bus.count),       32'(c));
    check({tag, " empty"},       32'(bus.empty),       32'(e));
    check({tag, " full"},        32'(bus.full),        32'(f));
    check({tag, " almost_full"}, 32'(bus.almost_full), 32'(a));
    check({tag, " dout"},        32'(bus.dout),        32'(d));
    check({tag, " push_err"},    32'(bus.push_err),    32'(pe));
    check({tag, " pop_err"},     32'(bus.pop_err),     32'(poe));
  endtask

  task automatic drive(input logic fl, input logic pu, input logic po, input logic [7:0] di);
    bus.flush = fl; bus.push = pu; bus.pop = po; bus.din = di;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // basic push/pop, almost_full threshold
    vecs.push_back(mk(0,1,0,8'h11, 3'd1,0,0,0,8'h11,0,0));
    vecs.push_back(mk(0,1,0,8'h22, 3'd2,0,0,0,8'h11,0,0));
    vecs.push_back(mk(0,1,0,8'h33, 3'd3,0,0,1,8'h11,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 3'd2,0,0,0,8'h22,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 3'd1,0,0,0,8'h33,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 3'd0,1,0,0,8'h00,0,0));
    // fill, rejected push, push+pop at full
    vecs.push_back(mk(0,1,0,8'hA0, 3'd1,0,0,0,8'hA0,0,0));
    vecs.push_back(mk(0,1,0,8'hA1, 3'd2,0,0,0,8'hA0,0,0));
    vecs.push_back(mk(0,1,0,8'hA2, 3'd3,0,0,1,8'hA0,0,0));
    vecs.push_back(mk(0,1,0,8'hA3, 3'd4,0,1,1,8'hA0,0,0));
    vecs.push_back(mk(0,1,0,8'hFF, 3'd4,0,1,1,8'hA0,1,0));
    vecs.push_back(mk(0,1,1,8'hB0, 3'd4,0,1,1,8'hA1,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 3'd3,0,0,1,8'hA2,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 3'd2,0,0,0,8'hA3,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 3'd1,0,0,0,8'hB0,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 3'd0,1,0,0,8'h00,0,0));
    // interleaved traffic across the pointer wrap
    vecs.push_back(mk(0,1,0,8'h01, 3'd1,0,0,0,8'h01,0,0));
    vecs.push_back(mk(0,1,0,8'h02, 3'd2,0,0,0,8'h01,0,0));
    vecs.push_back(mk(0,1,0,8'h03, 3'd3,0,0,1,8'h01,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 3'd2,0,0,0,8'h02,0,0));
    vecs.push_back(mk(0,1,0,8'h04, 3'd3,0,0,1,8'h02,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 3'd2,0,0,0,8'h03,0,0));
    vecs.push_back(mk(0,1,0,8'h05, 3'd3,0,0,1,8'h03,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 3'd2,0,0,0,8'h04,0,0));
    vecs.push_back(mk(0,1,0,8'h06, 3'd3,0,0,1,8'h04,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 3'd2,0,0,0,8'h05,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 3'd1,0,0,0,8'h06,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 3'd0,1,0,0,8'h00,0,0));
    // pop on empty: rejected, concurrent push still lands
    vecs.push_back(mk(0,1,1,8'h5A, 3'd1,0,0,0,8'h5A,0,1));
    vecs.push_back(mk(0,0,0,8'h00, 3'd1,0,0,0,8'h5A,0,0));
    // flush wins over push and pop
    vecs.push_back(mk(0,1,0,8'h66, 3'd2,0,0,0,8'h5A,0,0));
    vecs.push_back(mk(0,1,0,8'h77, 3'd3,0,0,1,8'h5A,0,0));
    vecs.push_back(mk(1,1,1,8'h99, 3'd0,1,0,0,8'h00,0,0));
    vecs.push_back(mk(0,0,0,8'h00, 3'd0,1,0,0,8'h00,0,0));
    // lone pop on empty, error lasts one cycle
    vecs.push_back(mk(0,0,1,8'h00, 3'd0,1,0,0,8'h00,0,1));
    vecs.push_back(mk(0,0,0,8'h00, 3'd0,1,0,0,8'h00,0,0));
    // flush with a pop on empty raises no error
    vecs.push_back(mk(1,0,1,8'h00, 3'd0,1,0,0,8'h00,0,0));

    #1 rst = 1'b1;
    #1 check_status("reset", 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].flush, vecs[i].push, vecs[i].pop, vecs[i].din);
      @(posedge clk);
      #1;
      check_status($sformatf("v%0d", i), vecs[i].cnt, vecs[i].emp, vecs[i].ful,
                   vecs[i].af, vecs[i].dout, vecs[i].pe, vecs[i].poe);
      @(negedge clk);
    end

    // async reset mid-cycle with two entries held
    drive(0, 1, 0, 8'hC1);
    @(posedge clk); @(negedge clk);
    drive(0, 1, 0, 8'hC2);
    @(posedge clk); @(negedge clk);
    drive(0, 0, 0, 8'h00);
    #1 check("pre_rst count", 32'(bus.count), 32'd2);
    #1 rst = 1'b1;
    #1 check_status("async_rst", 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 0, 8'h77);
    @(posedge clk);
    #1 check_status("post_rst", 3'd1, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
    @(negedge clk);

    // pending pop_err pulse is cleared by async reset
    drive(0, 0, 1, 8'h00);
    @(posedge clk); @(negedge clk);
    drive(0, 0, 1, 8'h00);
    @(posedge clk);
    #1 check("pop_err before rst", 32'(bus.pop_err), 32'd1);
    #1 rst = 1'b1;
    #1 check("pop_err cleared", 32'(bus.pop_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of entries (power of two, >=2).
REQ-003 Parameter AFULL_LEVEL, default 6, occupancy at or above which almost_full asserts (1..DEPTH).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous discard of all stored entries.
REQ-007 push  input  1  write request for din this cycle.
REQ-008 din  input  WIDTH  write data.
REQ-009 pop  input  1  read request; consumes the entry currently on dout.
REQ-010 dout  output  WIDTH  head entry, first-word-fall-through.
REQ-011 empty  output  1  occupancy == 0.
REQ-012 full  output  1  occupancy == DEPTH.
REQ-013 almost_full  output  1  occupancy >= AFULL_LEVEL.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 push_err  output  1  one-cycle pulse: previous cycle had a rejected push.
REQ-016 pop_err  output  1  one-cycle pulse: previous cycle had a rejected pop.

Function
REQ-017 Storage: DEPTH x WIDTH array; read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0; occupancy counter of $clog2(DEPTH)+1 bits.
REQ-018 Accepted push: writes din at the write pointer and advances it; takes effect on the next edge.
REQ-019 Accepted pop: advances the read pointer on the next edge; dout shows the new head in the following cycle with no extra latency.
REQ-020 dout shall equal the stored word at the read pointer when empty=0, and shall be all zeros when empty=1.
REQ-021 Push when full and pop=0: push rejected, storage unchanged, push_err=1 next cycle.
REQ-022 Push and pop together when full: both accepted, count unchanged, push_err=0.
REQ-023 Pop when empty: pop rejected, pop_err=1 next cycle; if push=1 in the same cycle, the push is still accepted (no bypass to dout that cycle), giving count=1 next cycle.
REQ-024 Push and pop together with 0<count<DEPTH: both accepted, count unchanged.
REQ-025 Flush=1: next edge sets pointers and count to 0; flush has priority over push and pop in the same cycle; neither is accepted and no error pulse is generated.
REQ-026 Status outputs empty, full, almost_full and count shall be derived combinationally from the occupancy register (they reflect state after the last edge).
REQ-027 push_err and pop_err are registered and assert for exactly one cycle per rejected request.
REQ-028 Storage contents are not reset or cleared by flush; only pointers and count are affected.

Reset
REQ-029 While rst=1, regardless of clk: pointers=0, count=0, push_err=0, pop_err=0; hence empty=1, full=0, almost_full=0, dout=0.
REQ-030 Reset asserted mid-operation discards all entries; the first edge after rst falls shall honour push/pop normally.

Verification (WIDTH=8, DEPTH=4, AFULL_LEVEL=3)
REQ-031 Reset, then push 0x11,0x22,0x33 on consecutive cycles -> count 1,2,3; almost_full=1 after the third; dout=0x11 throughout; pop x3 -> dout 0x22, 0x33, then empty=1 with dout=0x00.
REQ-032 Fill with 0xA0..0xA3 -> full=1; push 0xFF with pop=0 -> push_err pulse, count stays 4; then push 0xB0 with pop=1 -> count 4, the read sequence yields 0xA1,0xA2,0xA3,0xB0.
REQ-033 Wrap-around: push 6 and pop 6 interleaved, keeping count<=3 -> output order equals input order 0x01..0x06, with no errors.
REQ-034 Empty FIFO, push=1 din=0x5A with pop=1 -> pop_err pulse, count=1, dout=0x5A next cycle.
REQ-035 count=3, flush=1 with push=1 and pop=1 -> next cycle count=0, empty=1, dout=0x00, no error pulses.
REQ-036 count=2, assert rst asynchronously between edges -> empty=1 and count=0 immediately without a clock edge; after release, push 0x77 -> dout=0x77.
